// File: rtl/fetch_pkg.sv
// Shared types for the fetch stage: queue entry layout, fetch FSM states and instruction size.
package fetch_pkg;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STALL,
    FLUSH
  } fetch_state_t;

  localparam int INSTR_BYTES = 4;

endpackage : fetch_pkg

// File: rtl/fetch_fifo.sv
// Small fetch-entry FIFO with combinational head read and a flush that empties it in one cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int LOG_DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t dout,
  output logic         full,
  output logic         empty
);

  fetch_entry_t         r_mem [DEPTH];
  logic [LOG_DEPTH:0]   r_wr_ptr;
  logic [LOG_DEPTH:0]   r_rd_ptr;
  logic                 w_push;
  logic                 w_pop;

  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[LOG_DEPTH] != r_rd_ptr[LOG_DEPTH]) &&
                 (r_wr_ptr[LOG_DEPTH-1:0] == r_rd_ptr[LOG_DEPTH-1:0]);

  // A push into a full queue is only legal when the head leaves in the same cycle.
  assign w_pop  = pop & ~empty;
  assign w_push = push & (~full | w_pop);

  assign dout = r_mem[r_rd_ptr[LOG_DEPTH-1:0]];

  always_ff @(posedge clk) begin
    if (w_push && !flush) begin
      r_mem[r_wr_ptr[LOG_DEPTH-1:0]] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule : fetch_fifo

// File: rtl/fetch_queue.sv
// Fetch stage: owns the fetch PC, captures icache hits into a FIFO for decode, restarts on redirect.
// Optional FETCH_PERF_CNT_EN adds saturating push and stall-cycle counters.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter int          LOG_DEPTH = 2,
  parameter logic [63:0] RESET_PC  = 64'h0
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [63:0] sm_pc,
  input  logic [31:0] ir,
  input  logic        icache_valid,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        deq_valid,
  input  logic        deq_ready,
  output logic [31:0] deq_instr,
  output logic [63:0] deq_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);

  fetch_state_t r_state, r_state_next;
  logic [63:0]  r_pc, r_pc_next;
  logic         w_full;
  logic         w_empty;
  logic         w_deq_fire;
  logic         w_enq_ok;
  fetch_entry_t w_din;
  fetch_entry_t w_dout;

  assign sm_pc      = r_pc;
  assign deq_valid  = ~w_empty;
  assign deq_instr  = w_dout.instr;
  assign deq_pc     = w_dout.pc;
  assign w_deq_fire = deq_valid & deq_ready;
  assign w_enq_ok   = icache_valid & (~w_full | w_deq_fire) & ~redirect_valid & (r_state == RUN);
  assign w_din      = '{pc: r_pc, instr: ir};

  fetch_fifo #(
    .DEPTH    (DEPTH),
    .LOG_DEPTH(LOG_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .push   (w_enq_ok),
    .pop    (w_deq_fire),
    .flush  (redirect_valid),
    .din    (w_din),
    .dout   (w_dout),
    .full   (w_full),
    .empty  (w_empty)
  );

  always_comb begin
    r_state_next = r_state;
    r_pc_next    = r_pc;
    case (r_state)
      IDLE:    r_state_next = RUN;
      RUN:     if (!icache_valid) r_state_next = STALL;
      STALL:   if (icache_valid) r_state_next = RUN;
      FLUSH:   r_state_next = RUN;
      default: r_state_next = IDLE;
    endcase
    // Redirect wins over everything; FLUSH then holds the new PC steady for one cycle.
    if (redirect_valid) begin
      r_state_next = FLUSH;
      r_pc_next    = redirect_pc & ~64'h3;
    end else if (w_enq_ok) begin
      r_pc_next = r_pc + 64'(INSTR_BYTES);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= r_state_next;
      r_pc    <= r_pc_next;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_perf_fetched <= '0;
      r_perf_stall   <= '0;
    end else begin
      if (w_enq_ok && r_perf_fetched != 32'hFFFF_FFFF) r_perf_fetched <= r_perf_fetched + 1'b1;
      if (r_state == STALL && r_perf_stall != 32'hFFFF_FFFF) r_perf_stall <= r_perf_stall + 1'b1;
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_stall   = r_perf_stall;
`endif

endmodule : fetch_queue

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: reset, throughput, backpressure, stall, redirect, PC wrap, perf counters.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [63:0] sm_pc;
  logic [31:0] ir;
  logic        icache_valid;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        deq_valid;
  logic        deq_ready;
  logic [31:0] deq_instr;
  logic [63:0] deq_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Icache model: instruction word is a fixed function of its address.
  function automatic logic [31:0] instr_of(input logic [63:0] pc);
    return pc[31:0] ^ 32'h5A5A_0000;
  endfunction

  assign ir = instr_of(sm_pc);

  fetch_queue #(
    .DEPTH    (4),
    .LOG_DEPTH(2),
    .RESET_PC (64'h1000)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .sm_pc         (sm_pc),
    .ir            (ir),
    .icache_valid  (icache_valid),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .deq_valid     (deq_valid),
    .deq_ready     (deq_ready),
    .deq_instr     (deq_instr),
    .deq_pc        (deq_pc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched  (perf_fetched),
    .perf_stall    (perf_stall)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-14s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    int n;
    reset_n        = 1'b0;
    icache_valid   = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 64'h0;
    deq_ready      = 1'b1;

    // 1: reset values and one-per-cycle streaming
    do_reset();
    chk("rst_valid", {63'h0, deq_valid}, 64'h0);
    chk("rst_pc", sm_pc, 64'h1000);
    step();  // IDLE -> RUN
    chk("idle_valid", {63'h0, deq_valid}, 64'h0);
    chk("idle_pc", sm_pc, 64'h1000);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("strm_smpc", sm_pc, 64'h1004 + 64'(4 * k));
      chk("strm_valid", {63'h0, deq_valid}, 64'h1);
      chk("strm_deqpc", deq_pc, 64'h1000 + 64'(4 * k));
      chk("strm_instr", {32'h0, deq_instr}, {32'h0, instr_of(64'h1000 + 64'(4 * k))});
    end

    // 2: backpressure fills exactly DEPTH entries, then pop+push every cycle
    deq_ready = 1'b0;
    do_reset();
    for (int k = 0; k < 8; k++) step();
    chk("full_smpc", sm_pc, 64'h1010);
    chk("full_head", deq_pc, 64'h1000);
    deq_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("drain_valid", {63'h0, deq_valid}, 64'h1);
      chk("drain_deqpc", deq_pc, 64'h1004 + 64'(4 * k));
      chk("drain_smpc", sm_pc, 64'h1014 + 64'(4 * k));
    end

    // 3: miss at 0x1040 for 20 cycles
    n = 0;
    while (sm_pc != 64'h1040 && n < 50) begin
      step();
      n++;
    end
    chk("reach_1040", {63'h0, sm_pc == 64'h1040}, 64'h1);
    icache_valid = 1'b0;
    for (int k = 0; k < 20; k++) step();
    chk("stall_smpc", sm_pc, 64'h1040);
    chk("stall_empty", {63'h0, deq_valid}, 64'h0);
    icache_valid = 1'b1;
    step();  // STALL -> RUN
    chk("resume_smpc", sm_pc, 64'h1040);
    step();
    chk("resume_valid", {63'h0, deq_valid}, 64'h1);
    chk("resume_deqpc", deq_pc, 64'h1040);
    chk("resume_smpc2", sm_pc, 64'h1044);

    // 4: redirect with 3 queued entries and a simultaneous dequeue
    deq_ready = 1'b0;
    step();
    step();
    chk("q3_head", deq_pc, 64'h1040);
    chk("q3_smpc", sm_pc, 64'h104C);
    deq_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h2003;
    step();
    redirect_valid = 1'b0;
    chk("redir_valid", {63'h0, deq_valid}, 64'h0);
    chk("redir_smpc", sm_pc, 64'h2000);
    step();  // FLUSH -> RUN
    chk("flush_valid", {63'h0, deq_valid}, 64'h0);
    chk("flush_smpc", sm_pc, 64'h2000);
    step();
    chk("new_valid", {63'h0, deq_valid}, 64'h1);
    chk("new_deqpc", deq_pc, 64'h2000);
    chk("new_instr", {32'h0, deq_instr}, {32'h0, instr_of(64'h2000)});

    // 5: PC wrap, then reset mid-burst
    redirect_valid = 1'b1;
    redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    chk("wrap_start", sm_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    step();
    step();
    chk("wrap_smpc", sm_pc, 64'h0);
    chk("wrap_deqpc", deq_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    deq_ready = 1'b0;
    step();
    step();
    chk("burst_valid", {63'h0, deq_valid}, 64'h1);
    reset_n = 1'b0;
    step();
    chk("mrst_valid", {63'h0, deq_valid}, 64'h0);
    chk("mrst_smpc", sm_pc, 64'h1000);
    reset_n   = 1'b1;
    deq_ready = 1'b1;

`ifdef FETCH_PERF_CNT_EN
    // 6: 10 pushes then 5 cycles spent in STALL
    chk("perf_f_rst", {32'h0, perf_fetched}, 64'h0);
    chk("perf_s_rst", {32'h0, perf_stall}, 64'h0);
    step();  // IDLE -> RUN
    for (int k = 0; k < 10; k++) step();
    icache_valid = 1'b0;
    for (int k = 0; k < 6; k++) step();
    chk("perf_fetched", {32'h0, perf_fetched}, 64'd10);
    chk("perf_stall", {32'h0, perf_stall}, 64'd5);
    icache_valid = 1'b1;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_fetch_queue
